// File: rtl/wtm_mul8_sequencer.sv
// 8x8 unsigned multiplier built by time-multiplexing one 4x4 Wallace-tree
// multiplier over the four nibble partial products of the latched operands.

// 4x4 unsigned Wallace-tree multiplier: four shifted partial-product rows
// reduced by two carry-save levels, then one carry-propagate add.
module wallace_tree_multiplier (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  output logic [7:0] p_o
);
  logic [3:0][7:0] pp;
  logic [7:0] s1, c1, s2, c2;

  for (genvar i = 0; i < 4; i++) begin : g_pp
    assign pp[i] = {4'b0, a_i & {4{b_i[i]}}} << i;
  end

  // Two 3:2 compression levels; dropping carries out of bit 7 is exact
  // because the full product never exceeds 225.
  always_comb begin
    s1  = pp[0] ^ pp[1] ^ pp[2];
    c1  = ((pp[0] & pp[1]) | (pp[0] & pp[2]) | (pp[1] & pp[2])) << 1;
    s2  = s1 ^ c1 ^ pp[3];
    c2  = ((s1 & c1) | (s1 & pp[3]) | (c1 & pp[3])) << 1;
    p_o = s2 + c2;
  end
endmodule

module wtm_mul8_sequencer #(
  parameter bit ZERO_BYPASS = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] product,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [7:0]  a_q, a_d, b_q, b_d;
  logic [15:0] acc_q, acc_d, prod_q, prod_d;
  logic        ovld_q, ovld_d;

  logic [3:0]  mul_a, mul_b;
  logic [7:0]  mul_p;
  logic [15:0] part;

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = ovld_q;
  assign product   = prod_q;

  // Nibble select and weight of the current partial product; outside CALC
  // the multiplier sits on the step0 selection and its output is unused.
  always_comb begin
    mul_a = a_q[3:0];
    mul_b = b_q[3:0];
    part  = {8'b0, mul_p};
    if (state_q == CALC) begin
      case (step_q)
        2'd1: begin mul_b = b_q[7:4]; part = {4'b0, mul_p, 4'b0}; end
        2'd2: begin mul_a = a_q[7:4]; part = {4'b0, mul_p, 4'b0}; end
        2'd3: begin mul_a = a_q[7:4]; mul_b = b_q[7:4]; part = {mul_p, 8'b0}; end
        default: ;
      endcase
    end
  end

  wallace_tree_multiplier u_wtm (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  // Next-state: accept in IDLE, accumulate one nibble product per CALC
  // cycle, hold the result in DONE until the consumer takes it.
  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    ovld_d  = ovld_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = 16'd0;
          step_d  = 2'd0;
          state_d = CALC;
          if (ZERO_BYPASS && (a == 8'd0 || b == 8'd0)) begin
            prod_d  = 16'd0;
            ovld_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      CALC: begin
        acc_d  = acc_q + part;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
          prod_d  = acc_q + part;
          ovld_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          ovld_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q  <= 2'd0;
      a_q     <= 8'd0;
      b_q     <= 8'd0;
      acc_q   <= 16'd0;
      prod_q  <= 16'd0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      ovld_q  <= ovld_d;
    end
  end
endmodule

// File: tb/tb_wtm_mul8_sequencer.sv
// Directed bench: one instance without and one with zero bypass, sharing
// operand/out_ready drives; each instance has its own in_valid.
module tb_wtm_mul8_sequencer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        iv0 = 1'b0, iv1 = 1'b0;
  logic [7:0]  a = 8'd0, b = 8'd0;
  logic        out_ready = 1'b1;
  logic        ir0, ir1, ov0, ov1, bz0, bz1;
  logic [15:0] p0, p1;
  bit          sel = 1'b0;
  logic        ir_s, ov_s, bz_s;
  logic [15:0] p_s;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  wtm_mul8_sequencer #(.ZERO_BYPASS(1'b0)) u0 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv0), .in_ready(ir0), .a(a), .b(b),
    .out_valid(ov0), .out_ready(out_ready), .product(p0), .busy(bz0));
  wtm_mul8_sequencer #(.ZERO_BYPASS(1'b1)) u1 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv1), .in_ready(ir1), .a(a), .b(b),
    .out_valid(ov1), .out_ready(out_ready), .product(p1), .busy(bz1));

  assign ir_s = sel ? ir1 : ir0;
  assign ov_s = sel ? ov1 : ov0;
  assign bz_s = sel ? bz1 : bz0;
  assign p_s  = sel ? p1  : p0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // One operation on the selected instance; operands are scrambled right
  // after acceptance so any leak into the result shows up.
  task automatic op(input logic [7:0] ai, input logic [7:0] bi,
                    input logic [15:0] exp, input int lat, input bit hold);
    int cnt;
    check("in_ready_idle", ir_s, 1);
    a = ai; b = bi;
    if (sel) iv1 = 1'b1; else iv0 = 1'b1;
    @(posedge clk); #1;
    iv0 = 1'b0; iv1 = 1'b0;
    a = ~ai; b = bi + 8'd37;
    cnt = 0;
    while (!ov_s && cnt < 20) begin
      if (ir_s !== 1'b0 || bz_s !== 1'b1) check("busy_calc", {ir_s, bz_s}, 2'b01);
      @(posedge clk); #1;
      cnt++;
    end
    check("latency", cnt, lat);
    check("out_valid", ov_s, 1);
    check("product", p_s, exp);
    if (hold) begin
      for (int k = 0; k < 5; k++) begin
        @(posedge clk); #1;
        check("hold_valid", ov_s, 1);
        check("hold_product", p_s, exp);
        check("hold_in_ready", ir_s, 0);
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    check("valid_drop", ov_s, 0);
    check("in_ready_back", ir_s, 1);
    check("product_kept", p_s, exp);
  endtask

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] p;
  } vec_t;
  vec_t tbl[8];

  initial begin
    tbl[0] = '{8'd1,   8'd0,   16'd0};
    tbl[1] = '{8'd11,  8'd4,   16'd44};
    tbl[2] = '{8'd13,  8'd7,   16'd91};
    tbl[3] = '{8'd9,   8'd7,   16'd63};
    tbl[4] = '{8'd15,  8'd15,  16'd225};
    tbl[5] = '{8'd5,   8'd3,   16'd15};
    tbl[6] = '{8'd255, 8'd255, 16'd65025};
    tbl[7] = '{8'd200, 8'd170, 16'd34000};

    #12;
    check("rst_ov0", ov0, 0);
    check("rst_p0", p0, 0);
    check("rst_ir0", ir0, 1);
    check("rst_busy0", bz0, 0);
    check("rst_ov1", ov1, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    sel = 1'b0;
    for (int i = 0; i < 8; i++) op(tbl[i].a, tbl[i].b, tbl[i].p, 4, 1'b0);

    // Back-pressure: result held for 5 cycles, then one handshake.
    out_ready = 1'b0;
    op(8'd171, 8'd205, 16'd35055, 4, 1'b1);

    // Reset while at CALC step2 of 100*100.
    a = 8'd100; b = 8'd100; iv0 = 1'b1;
    @(posedge clk); #1; iv0 = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_ov", ov0, 0);
    check("midrst_p", p0, 0);
    check("midrst_ir", ir0, 1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_no_pulse", ov0, 0);
    op(8'd3, 8'd5, 16'd15, 4, 1'b0);

    // Zero bypass instance.
    sel = 1'b1;
    op(8'd0, 8'd77, 16'd0, 0, 1'b0);
    op(8'd16, 8'd16, 16'd256, 4, 1'b0);
    op(8'd77, 8'd0, 16'd0, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
